// File: rtl/ex_stage_skid_reg.sv
// Decode-to-execute stage register: valid/ready handshake with a 2-entry skid buffer.
// Optional perf counters enabled by defining EX_STAGE_PERF_CNT_EN.
module ex_stage_skid_reg #(
  parameter int PAYLOAD_W = 128,
  parameter int CTRL_W    = 3,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [REGADDR_W-1:0] in_write_reg,
  input  logic                 should_stall,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [REGADDR_W-1:0] out_write_reg
`ifdef EX_STAGE_PERF_CNT_EN
  ,
  output logic [15:0]          perf_bubbles,
  output logic [15:0]          perf_backpressure
`endif
);

  // State encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t                 state_reg;
  logic [PAYLOAD_W-1:0]   main_payload_reg, skid_payload_reg;
  logic [CTRL_W-1:0]      main_ctrl_reg, skid_ctrl_reg;
  logic [REGADDR_W-1:0]   main_write_reg_reg, skid_write_reg_reg;

  logic                   acc, deq;
  logic [CTRL_W-1:0]      in_ctrl_masked;

  assign in_ready       = ~state_reg[1];
  assign out_valid      = state_reg[0];
  assign out_payload    = main_payload_reg;
  assign out_ctrl       = main_ctrl_reg;
  assign out_write_reg  = main_write_reg_reg;

  assign acc            = in_valid & in_ready;
  assign deq            = out_valid & out_ready;
  assign in_ctrl_masked = should_stall ? '0 : in_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= EMPTY;
      main_payload_reg   <= '0;
      main_ctrl_reg      <= '0;
      main_write_reg_reg <= '0;
      skid_payload_reg   <= '0;
      skid_ctrl_reg      <= '0;
      skid_write_reg_reg <= '0;
    end else if (flush) begin
      // Payload may linger; only the side-effect bits must be squashed.
      state_reg     <= EMPTY;
      main_ctrl_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (acc) begin
            state_reg          <= ONE;
            main_payload_reg   <= in_payload;
            main_ctrl_reg      <= in_ctrl_masked;
            main_write_reg_reg <= in_write_reg;
          end
        end
        ONE: begin
          if (acc && deq) begin
            main_payload_reg   <= in_payload;
            main_ctrl_reg      <= in_ctrl_masked;
            main_write_reg_reg <= in_write_reg;
          end else if (acc) begin
            state_reg          <= FULL;
            skid_payload_reg   <= in_payload;
            skid_ctrl_reg      <= in_ctrl_masked;
            skid_write_reg_reg <= in_write_reg;
          end else if (deq) begin
            // Clearing ctrl keeps out_ctrl zero whenever out_valid is low.
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
          end
        end
        FULL: begin
          if (deq) begin
            state_reg          <= ONE;
            main_payload_reg   <= skid_payload_reg;
            main_ctrl_reg      <= skid_ctrl_reg;
            main_write_reg_reg <= skid_write_reg_reg;
            skid_ctrl_reg      <= '0;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          main_ctrl_reg <= '0;
          skid_ctrl_reg <= '0;
        end
      endcase
    end
  end

`ifdef EX_STAGE_PERF_CNT_EN
  logic [15:0] perf_bubbles_reg, perf_backpressure_reg;

  assign perf_bubbles      = perf_bubbles_reg;
  assign perf_backpressure = perf_backpressure_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubbles_reg      <= '0;
      perf_backpressure_reg <= '0;
    end else begin
      if (acc && should_stall && perf_bubbles_reg != 16'hFFFF)
        perf_bubbles_reg <= perf_bubbles_reg + 16'd1;
      if (out_valid && !out_ready && perf_backpressure_reg != 16'hFFFF)
        perf_backpressure_reg <= perf_backpressure_reg + 16'd1;
    end
  end
`endif

endmodule
